// File: rtl/spi_apb_arbiter_pkg.sv
// Shared types and constants for the SPI APB arbiter.
package spi_apb_arbiter_pkg;

  // APB master phase sequencing
  typedef enum logic [1:0] {
    SPI_ARB_IDLE   = 2'd0,
    SPI_ARB_SETUP  = 2'd1,
    SPI_ARB_ACCESS = 2'd2
  } spi_arb_state_e;

  // Idle owner cycles before an abandoned lock is revoked
  localparam int SPI_ARB_LOCK_TIMEOUT_DEFAULT = 1024;

  // Width of an index able to address n entries (at least one bit)
  function automatic int spi_arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_apb_arbiter_if.sv
// APB4 bus between the arbiter (master) and the SPI register slave.
interface spi_apb_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pwrite, pwdata, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, pwdata, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/spi_apb_arbiter_rr.sv
// Combinational round-robin picker: first eligible index at or after ptr_i,
// wrapping modulo N. Kept generic so other shared peripherals can reuse it.
module spi_rr_arbiter
  import spi_apb_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = spi_arb_idx_w(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest eligible entry wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(N)) begin
        sum = sum - (IDX_W + 1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (eligible_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_apb_arbiter.sv
// Round-robin APB4 master sharing one SPI register port between NUM_REQ
// requesters, with per-owner locking and an abandoned-lock timeout.
module spi_apb_arbiter
  import spi_apb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = SPI_ARB_LOCK_TIMEOUT_DEFAULT
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic                      req_err_o,
  output logic [NUM_REQ-1:0]        owner_o,
  output logic                      lock_revoked_o,
  spi_apb_arbiter_if.master         apb
);

  localparam int  IDX_W      = spi_arb_idx_w(NUM_REQ);
  localparam bit  TIMEOUT_EN = (LOCK_TIMEOUT > 0);
  localparam int  CNT_W      = spi_arb_idx_w(LOCK_TIMEOUT + 1);
  // Counter value on the last idle cycle before revocation
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  spi_arb_state_e     state_q;
  logic [NUM_REQ-1:0] owner_q;
  logic [IDX_W-1:0]   owner_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               revoked_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic               pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic               psel_q;
  logic               penable_q;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               lock_held;
  logic               access_done;

  // Unpack the flat request buses into per-requester entries
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A held lock narrows eligibility to the owner; otherwise everyone competes
  assign lock_held = |(owner_q & req_lock_i);
  assign eligible  = lock_held ? (owner_q & req_valid_i) : req_valid_i;

  spi_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .eligible_i (eligible),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .idx_o      (grant_idx),
    .valid_o    (grant_valid)
  );

  // Completion is visible to the requester in the same cycle pready arrives
  assign access_done    = (state_q == SPI_ARB_ACCESS) && apb.pready;
  assign req_ack_o      = access_done ? owner_q : '0;
  assign req_rdata_o    = access_done ? apb.prdata : '0;
  assign req_err_o      = access_done & apb.pslverr;
  assign owner_o        = owner_q;
  assign lock_revoked_o = revoked_q;

  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;

  // Arbitration, APB phase sequencing, ownership and lock timeout
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= SPI_ARB_IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      revoked_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      revoked_q <= 1'b0;
      case (state_q)
        SPI_ARB_IDLE: begin
          if (grant_valid) begin
            paddr_q     <= addr_arr[grant_idx];
            pwrite_q    <= req_write_i[grant_idx];
            pwdata_q    <= wdata_arr[grant_idx];
            owner_q     <= grant;
            owner_idx_q <= grant_idx;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SPI_ARB_SETUP;
          end else if (lock_held) begin
            // Lock held but owner silent (a requesting owner would have won)
            if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
              owner_q   <= '0;
              cnt_q     <= '0;
              revoked_q <= 1'b1;
            end else if (TIMEOUT_EN) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            // Owner dropped its lock while idle: release without moving rr_ptr
            owner_q <= '0;
            cnt_q   <= '0;
          end
        end
        SPI_ARB_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= SPI_ARB_ACCESS;
        end
        SPI_ARB_ACCESS: begin
          cnt_q <= '0;
          if (apb.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= SPI_ARB_IDLE;
            rr_ptr_q  <= (owner_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                              : owner_idx_q + IDX_W'(1);
            if (!lock_held) begin
              owner_q <= '0;
            end
          end
        end
        default: begin
          state_q   <= SPI_ARB_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
